expr_arbiter: RTL and testbench
===============================

// Module: expr_arbiter
// PURPOSE
//  Shares one arithmetic-expression checker between two byte-stream requesters. Grammar: digit ((+|*) digit)*.
//  Arbitrates round-robin per whole expression and frames each expression on a delimiter byte.
//  Sequences the checker: clears it per expression and steps it per byte.
//  Returns one verdict record per expression over a valid/ready result port. Sits between char sources and the report logic.
// PARAMETERS
//  DELIM    8'h3B  expression terminator byte (';'); consumed, never counted or checked
//  MAX_LEN  16     max non-delimiter bytes per expression; more forces verdict fail
//  LEN_W    5      width of res_len; must satisfy 2**LEN_W > MAX_LEN
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  clr_n       in   1      reset, asynchronous, active-low
//  req0_valid  in   1      requester 0 byte valid
//  req0_data   in   8      requester 0 ASCII byte
//  req0_ready  out  1      requester 0 byte accepted this cycle (when valid)
//  req1_valid  in   1      requester 1 byte valid
//  req1_data   in   8      requester 1 ASCII byte
//  req1_ready  out  1      requester 1 byte accepted this cycle (when valid)
//  res_valid   out  1      verdict record available
//  res_ok      out  1      1 = expression well-formed
//  res_src     out  1      requester index that produced the expression
//  res_len     out  LEW_W  non-delimiter bytes accepted, saturating at MAX_LEN
//  res_ready   in   1      consumer takes the record
//  busy        out  1      high in RUN or REPORT
// BEHAVIOUR
//  Reset (clr_n=0, async): state=IDLE; last_grant=1, so req0 wins the first tie.
//   All outputs 0; checker cleared; len=0; ovf=0.
//  Top FSM: IDLE -> RUN -> REPORT -> IDLE.
//  IDLE: both readies 0.
//   One valid: grant it.
//   Both valid: grant the one != last_grant.
//   Registered grant; next state RUN. No valid: stay.
//  RUN: only the granted reqX_ready=1; the other is 0. A byte transfers when valid&&ready.
//   Non-DELIM byte: checker steps; len<=len+1 if len<MAX_LEN, else ovf<=1 and len holds.
//   DELIM byte: latch the verdict into res_*; next state REPORT.
//   Granted valid=0: wait. No timeout; the grant is held.
//  REPORT: res_valid=1; res_* stable. Both readies 0.
//   On res_ready=1: clear the checker, len and ovf.
//   Set last_grant=res_src; next state IDLE; res_valid drops the next cycle.
//  Checker states:
//   EXP_DIG (initial): digit '0'..'9' -> AFT_DIG; else -> ERR.
//   AFT_DIG: '+' or '*' -> EXP_DIG; else -> ERR.
//   ERR: absorbing.
//  Verdict: res_ok = (chk==AFT_DIG) && !ovf. An empty expression (DELIM first) gives ok=0, len=0.
//  Latency and throughput:
//   DELIM accepted at edge t -> res_valid=1 from t.
//   Result handshake at edge t -> IDLE. Grant at t+1 -> ready=1 after edge t+1.
//   One byte per cycle within an expression.
//  Simultaneous events:
//   A new valid during REPORT is ignored until IDLE.
//   A non-granted requester stays stalled for the whole expression, however long.
//  Reset mid-operation: immediate return to the reset state.
//   The partial expression is discarded; no record is emitted.
// STRUCTURE
//  Shared package expr_pkg:
//   ASCII constants CH_0=8'h30, CH_9=8'h39, CH_ADD=8'h2B, CH_MUL=8'h2A, CH_DELIM=8'h3B.
//   Top FSM state enum {IDLE,RUN,REPORT}; checker enum {EXP_DIG,AFT_DIG,ERR}.
//  Sub-module expr_check (clk, clr_n, clear, step, ch[7:0], ok): holds the checker FSM only.
//  Top level holds the arbiter, framing FSM, len/ovf counter and result registers.
// TESTING
//  1 req0 "3+4*5;" only -> one record: ok=1 src=0 len=5; req1_ready stays 0.
//  2 req1 "3+;" then req1 ";" -> records ok=0 len=2 src=1, then ok=0 len=0 src=1.
//  3 After reset, both valid at once, each sending "7;" -> req0 served first, then req1.
//    req1_ready=0 throughout req0's expression; records in src order 0, 1.
//  4 req0 sends "1+1+1+1+1+1+1+1+1;" (17 non-delimiter bytes) -> ok=0, len=16.
//  5 res_ready held 0 for 5 cycles after res_valid -> record fields stable, both readies 0.
//    res_ready=1 -> res_valid=0 next cycle; a pending requester is then granted.
//  6 clr_n pulsed low mid "5*6" -> all outputs 0 immediately; no record.
//    A following "9;" yields ok=1, len=1.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants and state types for the expression arbiter and its checker.
package expr_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_ADD   = 8'h2B;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DELIM = 8'h3B;

  typedef enum logic [1:0] {IDLE, RUN, REPORT} top_state_e;
  typedef enum logic [1:0] {EXP_DIG, AFT_DIG, ERR} chk_state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_ADD) || (c == CH_MUL);
  endfunction

endpackage

// File: rtl/expr_arbiter_if.sv
// Byte-stream request ports, verdict result port and busy flag of the arbiter.
interface expr_arbiter_if #(
  parameter int unsigned LEN_W = 5
);
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ok;
  logic             res_src;
  logic [LEN_W-1:0] res_len;
  logic             res_ready;
  logic             busy;

  // Master drives the byte streams and consumes verdicts.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_ok, res_src, res_len, busy
  );

  // Slave is the arbiter itself.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_ok, res_src, res_len, busy
  );
endinterface

// File: rtl/expr_check.sv
// Grammar checker for digit ((+|*) digit)*, advanced one byte per step.
module expr_check
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clear,
  input  logic       step,
  input  logic [7:0] ch,
  output logic       ok
);

  chk_state_e state_q, state_d;

  // Checker state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= EXP_DIG;
    else        state_q <= state_d;
  end

  // Next-state: clear wins over step; ERR is absorbing.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EXP_DIG;
    end else if (step) begin
      case (state_q)
        EXP_DIG: state_d = is_digit(ch) ? AFT_DIG : ERR;
        AFT_DIG: state_d = is_op(ch) ? EXP_DIG : ERR;
        default: state_d = ERR;
      endcase
    end
  end

  assign ok = (state_q == AFT_DIG);

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin arbiter framing whole expressions from two requesters onto one checker.
module expr_arbiter
  import expr_pkg::*;
#(
  parameter logic [7:0]  DELIM   = CH_DELIM,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input logic           clk,
  input logic           clr_n,
  expr_arbiter_if.slave bus
);

  top_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             res_ok_q, res_ok_d;
  logic             res_src_q, res_src_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;

  logic             ready0, ready1;
  logic             chk_clear, chk_step, chk_ok;
  logic             sel_valid;
  logic [7:0]       sel_data;

  assign sel_valid = grant_q ? bus.req1_valid : bus.req0_valid;
  assign sel_data  = grant_q ? bus.req1_data  : bus.req0_data;

  expr_check u_check (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (chk_clear),
    .step  (chk_step),
    .ch    (sel_data),
    .ok    (chk_ok)
  );

  // State, grant, length counter and result registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      res_ok_q     <= 1'b0;
      res_src_q    <= 1'b0;
      res_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      res_ok_q     <= res_ok_d;
      res_src_q    <= res_src_d;
      res_len_q    <= res_len_d;
    end
  end

  // Framing FSM: grant in IDLE, stream bytes in RUN, hold the verdict in REPORT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    res_ok_d     = res_ok_q;
    res_src_d    = res_src_q;
    res_len_d    = res_len_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    chk_clear    = 1'b0;
    chk_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          grant_d = ~last_grant_q;
          state_d = RUN;
        end else if (bus.req0_valid) begin
          grant_d = 1'b0;
          state_d = RUN;
        end else if (bus.req1_valid) begin
          grant_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        ready0 = ~grant_q;
        ready1 = grant_q;
        if (sel_valid) begin
          if (sel_data == DELIM) begin
            res_ok_d  = chk_ok && !ovf_q;
            res_len_d = len_q;
            res_src_d = grant_q;
            state_d   = REPORT;
          end else begin
            chk_step = 1'b1;
            if (len_q < LEN_W'(MAX_LEN)) len_d = len_q + LEN_W'(1);
            else                          ovf_d = 1'b1;
          end
        end
      end
      REPORT: begin
        if (bus.res_ready) begin
          chk_clear    = 1'b1;
          len_d        = '0;
          ovf_d        = 1'b0;
          last_grant_d = res_src_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = (state_q == REPORT);
  assign bus.res_ok     = res_ok_q;
  assign bus.res_src    = res_src_q;
  assign bus.res_len    = res_len_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_expr_arbiter.sv
// Self-checking bench for expr_arbiter: directed scenarios plus randomized expressions.
module tb_expr_arbiter;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Monitor counters, only ever incremented.
  int r1_hi = 0;
  int both_hi = 0;
  int rep_rdy = 0;
  int val_hi = 0;

  expr_arbiter_if #(.LEN_W(5)) bus ();

  expr_arbiter dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Track ready/valid activity sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.req1_ready) r1_hi <= r1_hi + 1;
    if (bus.req0_ready && bus.req1_ready) both_hi <= both_hi + 1;
    if (bus.res_valid && (bus.req0_ready || bus.req1_ready)) rep_rdy <= rep_rdy + 1;
    if (bus.res_valid) val_hi <= val_hi + 1;
  end

  // Reference model: grammar match on the body (delimiter excluded) plus length limit.
  function automatic bit model_ok(input string s);
    byte c;
    if (s.len() == 0 || s.len() > 16 || (s.len() % 2) == 0) return 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (i % 2 == 0) begin
        if (!(c >= 8'h30 && c <= 8'h39)) return 1'b0;
      end else begin
        if (!(c == 8'h2B || c == 8'h2A)) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int model_len(input string s);
    return (s.len() > 16) ? 16 : s.len();
  endfunction

  function automatic string rand_body();
    string s = "";
    int    n = $urandom_range(0, 19);
    bit    shaped = $urandom_range(0, 1);
    int    r;
    byte   c;
    for (int i = 0; i < n; i++) begin
      if (shaped) begin
        if (i % 2 == 0) c = 8'h30 + 8'($urandom_range(0, 9));
        else            c = $urandom_range(0, 1) ? 8'h2B : 8'h2A;
      end else begin
        r = $urandom_range(0, 13);
        if (r < 10)       c = 8'h30 + 8'(r);
        else if (r == 10) c = 8'h2B;
        else if (r == 11) c = 8'h2A;
        else if (r == 12) c = 8'h78;
        else              c = 8'h20;
      end
      s = $sformatf("%s%c", s, c);
    end
    return s;
  endfunction

  task automatic set_req(input int src, input logic v, input logic [7:0] d);
    if (src == 0) begin
      bus.req0_valid = v;
      bus.req0_data  = d;
    end else begin
      bus.req1_valid = v;
      bus.req1_data  = d;
    end
  endtask

  function automatic logic get_ready(input int src);
    return (src == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Present the bytes of s one per cycle, holding each until accepted.
  task automatic drive_expr(input int src, input string s, output bit to);
    int i = 0;
    int waited = 0;
    to = 1'b0;
    while (i < s.len()) begin
      @(negedge clk);
      set_req(src, 1'b1, s[i]);
      #1;
      if (get_ready(src)) begin
        i++;
      end else begin
        waited++;
        if (waited > 300) begin
          to = 1'b1;
          break;
        end
      end
    end
    @(negedge clk);
    set_req(src, 1'b0, 8'h00);
  endtask

  // Wait for a verdict, stall it for hold cycles, then take it.
  task automatic get_record(input int hold, output logic ok, output logic src,
                            output logic [4:0] len, output bit to);
    int w = 0;
    to = 1'b0;
    ok = 1'b0;
    src = 1'b0;
    len = '0;
    @(negedge clk);
    while (!bus.res_valid) begin
      w++;
      if (w > 400) begin
        to = 1'b1;
        return;
      end
      @(negedge clk);
    end
    ok  = bus.res_ok;
    src = bus.res_src;
    len = bus.res_len;
    repeat (hold) @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clr_n = 1'b0;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Compare one verdict record and its timeout flag against expectations.
  task automatic chk_rec(input string name, input bit to, input logic ok, input logic src,
                         input logic [4:0] len, input bit e_ok, input bit e_src, input int e_len);
    n_cmp++;
    if (to) begin
      n_fail++;
      $display("FAIL %s timeout: got no record, required one", name);
    end
    n_cmp++;
    if ({ok, src, len} !== {e_ok, e_src, 5'(e_len)}) begin
      n_fail++;
      $display("FAIL %s record: got ok=%0b src=%0b len=%0d, required ok=%0b src=%0b len=%0d",
               name, ok, src, len, e_ok, e_src, e_len);
    end
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    clr_n = 1'b0;
    set_req(0, 1'b1, 8'h31);
    set_req(1, 1'b1, 8'h32);
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    outs = {bus.res_valid, bus.res_ok, bus.res_src, bus.res_len, bus.req0_ready,
            bus.req1_ready, bus.busy};
    n_cmp++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero", outs);
    end
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_single();
    bit to, tr;
    logic ok, src;
    logic [4:0] len;
    int snap = r1_hi;
    drive_expr(0, "3+4*5;", to);
    get_record(0, ok, src, len, tr);
    chk_rec("single", to | tr, ok, src, len, 1'b1, 1'b0, 5);
    n_cmp++;
    if (r1_hi - snap !== 0) begin
      n_fail++;
      $display("FAIL single_r1_ready: got %0d cycles high, required 0", r1_hi - snap);
    end
  endtask

  task automatic test_empty();
    bit to, tr;
    logic ok, src;
    logic [4:0] len;
    drive_expr(1, "3+;", to);
    get_record(0, ok, src, len, tr);
    chk_rec("trailing_op", to | tr, ok, src, len, 1'b0, 1'b1, 2);
    drive_expr(1, ";", to);
    get_record(0, ok, src, len, tr);
    chk_rec("empty", to | tr, ok, src, len, 1'b0, 1'b1, 0);
  endtask

  task automatic test_tie();
    bit to0, to1, ta, tb;
    logic ok_a, src_a, ok_b, src_b;
    logic [4:0] len_a, len_b;
    int snap, r1_during;
    apply_reset();
    snap = r1_hi;
    fork
      drive_expr(0, "7;", to0);
      drive_expr(1, "7;", to1);
      begin
        get_record(0, ok_a, src_a, len_a, ta);
        r1_during = r1_hi - snap;
        get_record(0, ok_b, src_b, len_b, tb);
      end
    join
    chk_rec("tie_first", to0 | ta, ok_a, src_a, len_a, 1'b1, 1'b0, 1);
    chk_rec("tie_second", to1 | tb, ok_b, src_b, len_b, 1'b1, 1'b1, 1);
    n_cmp++;
    if (r1_during !== 0) begin
      n_fail++;
      $display("FAIL tie_r1_stall: got %0d cycles high, required 0", r1_during);
    end
  endtask

  task automatic test_overflow();
    bit to, tr;
    logic ok, src;
    logic [4:0] len;
    drive_expr(0, "1+1+1+1+1+1+1+1+1;", to);
    get_record(0, ok, src, len, tr);
    chk_rec("overflow", to | tr, ok, src, len, 1'b0, 1'b0, 16);
  endtask

  task automatic test_backpressure();
    bit to0, to1, tb, tw;
    logic ok, src;
    logic [4:0] len;
    int w;
    tw = 1'b0;
    fork
      drive_expr(0, "2;", to0);
      begin
        repeat (3) @(negedge clk);
        drive_expr(1, "3;", to1);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!bus.res_valid && w < 50) begin
          w++;
          @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          n_cmp++;
          if ({bus.res_valid, bus.res_ok, bus.res_src, bus.res_len} !== {3'b110, 5'd1}) begin
            n_fail++;
            $display("FAIL hold_fields c%0d: got v=%0b ok=%0b src=%0b len=%0d, required 1 1 0 1",
                     c, bus.res_valid, bus.res_ok, bus.res_src, bus.res_len);
          end
          n_cmp++;
          if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_readies c%0d: got %b, required 00", c,
                     {bus.req0_ready, bus.req1_ready});
          end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_cmp++;
        if (bus.res_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL release_valid: got %0b, required 0", bus.res_valid);
        end
        w = 0;
        while (!bus.req1_ready && w < 3) begin
          w++;
          @(negedge clk);
        end
        n_cmp++;
        if (w !== 1) begin
          n_fail++;
          $display("FAIL pending_grant: got ready after %0d cycles, required 1", w);
        end
        get_record(0, ok, src, len, tb);
      end
    join
    chk_rec("after_release", to1 | tb | to0, ok, src, len, 1'b1, 1'b1, 1);
  endtask

  task automatic test_reset_mid();
    bit to, tr;
    logic ok, src;
    logic [4:0] len;
    logic [10:0] outs;
    int snap;
    drive_expr(0, "5*6", to);
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    outs = {bus.res_valid, bus.res_ok, bus.res_src, bus.res_len, bus.req0_ready,
            bus.req1_ready, bus.busy};
    n_cmp++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, required all zero", outs);
    end
    snap = val_hi;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (val_hi - snap !== 0) begin
      n_fail++;
      $display("FAIL midreset_record: got %0d valid cycles, required 0", val_hi - snap);
    end
    drive_expr(0, "9;", tr);
    get_record(0, ok, src, len, tr);
    chk_rec("after_midreset", to | tr, ok, src, len, 1'b1, 1'b0, 1);
  endtask

  task automatic test_random();
    localparam int N = 12;
    string b0[$];
    string b1[$];
    string e0[$];
    string e1[$];
    string exp_s;
    bit to0, to1, tr;
    logic ok, src;
    logic [4:0] len;
    for (int i = 0; i < N; i++) begin
      b0.push_back(rand_body());
      b1.push_back(rand_body());
    end
    e0 = b0;
    e1 = b1;
    to0 = 1'b0;
    to1 = 1'b0;
    fork
      begin
        bit t;
        foreach (b0[i]) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          drive_expr(0, {b0[i], ";"}, t);
          to0 |= t;
        end
      end
      begin
        bit t;
        foreach (b1[i]) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          drive_expr(1, {b1[i], ";"}, t);
          to1 |= t;
        end
      end
      begin
        for (int k = 0; k < 2 * N; k++) begin
          get_record($urandom_range(0, 3), ok, src, len, tr);
          if (tr) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rand_rec%0d timeout: got no record, required one", k);
            break;
          end
          if (src == 1'b0 && e0.size() > 0) exp_s = e0.pop_front();
          else if (src == 1'b1 && e1.size() > 0) exp_s = e1.pop_front();
          else exp_s = "<none>";
          n_cmp++;
          if ({ok, len} !== {model_ok(exp_s), 5'(model_len(exp_s))} || exp_s == "<none>") begin
            n_fail++;
            $display("FAIL rand_rec%0d src=%0b \"%s\": got ok=%0b len=%0d, required ok=%0b len=%0d",
                     k, src, exp_s, ok, len, model_ok(exp_s), model_len(exp_s));
          end
        end
      end
    join
    n_cmp++;
    if (to0 || to1 || e0.size() != 0 || e1.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d/%0d unserved, required 0/0", e0.size(), e1.size());
    end
  endtask

  initial begin
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_empty();
    test_tie();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    @(negedge clk);
    n_cmp++;
    if (both_hi !== 0 || rep_rdy !== 0) begin
      n_fail++;
      $display("FAIL ready_exclusive: got both=%0d report=%0d cycles, required 0 0",
               both_hi, rep_rdy);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
